calc_entry_ctrl: RTL and testbench

Sequencing controller for the keypad calculator. It consumes decoded key events from the keypad scanner/comparator and builds operand 1 (with sign), the operator and operand 2. It then launches the arithmetic unit with a start/done handshake and holds the result phase for the display multiplexer. It sits between the key comparator and the operation/result-digit blocks, replacing the free-running display-driven entry path.

---
 rtl/calc_pkg.sv | 49 ++++
 rtl/calc_digit_acc.sv | 27 ++
 rtl/calc_entry_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the keypad calculator entry path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

   // Operand geometry: three decimal digits fit in 10 bits; the x10+d product needs 14
   localparam int MAXDIG_DEF = 3;
   localparam int NUM_W      = 10;
   localparam int ACC_W      = 14;
   localparam int CNT_W      = 2;
   localparam int RES_W      = 20;

   localparam logic [NUM_W-1:0] MAX_OPERAND = 10'd999;

   // Operator/control key codes (key_type = 1)
   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_MUL = 4'hC;
   localparam logic [3:0] KEY_DIV = 4'hD;
   localparam logic [3:0] KEY_EQ  = 4'hE;
   localparam logic [3:0] KEY_CLR = 4'hF;

   // Operator encodings presented to the arithmetic unit
   localparam logic [1:0] OPER_ADD = 2'b00;
   localparam logic [1:0] OPER_SUB = 2'b01;
   localparam logic [1:0] OPER_MUL = 2'b10;
   localparam logic [1:0] OPER_DIV = 2'b11;

   typedef enum logic [2:0] {
      PH_ENTA  = 3'd0,
      PH_ENTOP = 3'd1,
      PH_ENTB  = 3'd2,
      PH_EXEC  = 3'd3,
      PH_WAIT  = 3'd4,
      PH_SHOW  = 3'd5,
      PH_ERR   = 3'd6
   } phase_t;

   // True for the four arithmetic operator keys A..D
   function automatic logic is_arith_key(input logic [3:0] code);
      return (code >= KEY_ADD) && (code <= KEY_DIV);
   endfunction

   // A..D map in order onto add/sub/mul/div
   function automatic logic [1:0] key_to_oper(input logic [3:0] code);
      return 2'(code - KEY_ADD);
   endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal digit accumulator: next = acc*10 + digit with a per-operand digit cap.
// Latency: combinational; the caller owns the value and count registers.
// Backpressure: digits past MAXDIG (or codes above 9) are refused via accept=0.
module calc_digit_acc
   import calc_pkg::*;
#(
   parameter int MAXDIG = MAXDIG_DEF
) (
   input  logic [NUM_W-1:0] acc,
   input  logic [CNT_W-1:0] cnt,
   input  logic [3:0]       digit,
   output logic [NUM_W-1:0] acc_nxt,
   output logic [CNT_W-1:0] cnt_nxt,
   output logic             accept
);

   logic [ACC_W-1:0] prod;

   // Widen before multiplying so the x10 never wraps; the cap keeps the result within 10 bits
   always_comb begin
      prod    = ACC_W'(acc) * ACC_W'(10) + ACC_W'(digit);
      accept  = (32'(cnt) < MAXDIG) && (digit <= 4'd9);
      acc_nxt = accept ? prod[NUM_W-1:0] : acc;
      cnt_nxt = accept ? cnt + CNT_W'(1) : cnt;
   end

endmodule

// File: rtl/calc_entry_ctrl.sv
// Keypad calculator entry sequencer: operand/operator entry, launch, result hold; CALC_CHAIN_EN chains results from SHOW.
// Latency: all outputs registered one edge after an accepted key; '=' to op_start is one cycle.
// Backpressure: none on keys (out-of-phase keys are dropped); op_done awaited up to TIMEOUT cycles, then ERR.
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int MAXDIG  = MAXDIG_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   input  logic             key_type,
   input  logic             op_done,
   input  logic [RES_W-1:0] res_mag,
   input  logic             res_neg,
   output logic [NUM_W-1:0] num1,
   output logic [NUM_W-1:0] num2,
   output logic             sig1,
   output logic [1:0]       oper,
   output logic             op_start,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] ndig,
   output logic             err
);

   localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   // Last WAIT count: ERR is taken on the edge where the counter would reach TIMEOUT-1,
   // which lands exactly TIMEOUT cycles after op_start rose
   localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 2);

   phase_t           state;
   logic [TCW-1:0]   to_cnt;

   logic             is_digit;
   logic             is_op;
   logic             is_sub;
   logic             is_eq;
   logic             is_clr;

   logic [NUM_W-1:0] a_nxt;
   logic [CNT_W-1:0] a_cnt_nxt;
   logic             a_accept;
   logic [NUM_W-1:0] b_nxt;
   logic [CNT_W-1:0] b_cnt_nxt;
   logic             b_accept;

   assign phase = state;

   // Decode the key event into the few classes the sequencer reacts to
   always_comb begin
      is_digit = key_valid && !key_type && (key_code <= 4'd9);
      is_op    = key_valid && key_type && is_arith_key(key_code);
      is_sub   = key_valid && key_type && (key_code == KEY_SUB);
      is_eq    = key_valid && key_type && (key_code == KEY_EQ);
      is_clr   = key_valid && key_type && (key_code == KEY_CLR);
   end

   // ndig always tracks the operand being edited, so both accumulators count from it
   calc_digit_acc #(.MAXDIG(MAXDIG)) u_acc_a (
      .acc     (num1),
      .cnt     (ndig),
      .digit   (key_code),
      .acc_nxt (a_nxt),
      .cnt_nxt (a_cnt_nxt),
      .accept  (a_accept)
   );

   calc_digit_acc #(.MAXDIG(MAXDIG)) u_acc_b (
      .acc     (num2),
      .cnt     (ndig),
      .digit   (key_code),
      .acc_nxt (b_nxt),
      .cnt_nxt (b_cnt_nxt),
      .accept  (b_accept)
   );

`ifndef CALC_CHAIN_EN
   // Result inputs only matter when chaining out of SHOW
   logic unused_res;
   assign unused_res = ^{res_mag, res_neg};
`endif

   // Sequencer: clear behaves exactly like reset, so a late op_done can never leak through
   always_ff @(posedge clk) begin
      if (rst || is_clr) begin
         state    <= PH_ENTA;
         num1     <= '0;
         num2     <= '0;
         sig1     <= 1'b0;
         oper     <= OPER_ADD;
         op_start <= 1'b0;
         ndig     <= '0;
         err      <= 1'b0;
         to_cnt   <= '0;
      end else begin
         op_start <= 1'b0;
         case (state)
            PH_ENTA: begin
               if (is_digit && a_accept) begin
                  num1 <= a_nxt;
                  ndig <= a_cnt_nxt;
               end else if (is_sub && (ndig == '0)) begin
                  sig1 <= ~sig1;
               end else if (is_op && (ndig != '0)) begin
                  oper  <= key_to_oper(key_code);
                  state <= PH_ENTOP;
               end
            end
            PH_ENTOP: begin
               if (is_op) begin
                  oper <= key_to_oper(key_code);
               end else if (is_digit) begin
                  num2  <= NUM_W'(key_code);
                  ndig  <= CNT_W'(1);
                  state <= PH_ENTB;
               end
            end
            PH_ENTB: begin
               if (is_digit && b_accept) begin
                  num2 <= b_nxt;
                  ndig <= b_cnt_nxt;
               end else if (is_eq) begin
                  if ((oper == OPER_DIV) && (num2 == '0)) begin
                     err   <= 1'b1;
                     state <= PH_ERR;
                  end else begin
                     op_start <= 1'b1;
                     state    <= PH_EXEC;
                  end
               end
            end
            PH_EXEC: begin
               to_cnt <= '0;
               state  <= PH_WAIT;
            end
            PH_WAIT: begin
               if (op_done) begin
                  state <= PH_SHOW;
               end else if (to_cnt == TO_LAST) begin
                  err   <= 1'b1;
                  state <= PH_ERR;
               end else begin
                  to_cnt <= to_cnt + TCW'(1);
               end
            end
            PH_SHOW: begin
               if (is_digit) begin
                  num1  <= NUM_W'(key_code);
                  num2  <= '0;
                  sig1  <= 1'b0;
                  oper  <= OPER_ADD;
                  ndig  <= CNT_W'(1);
                  state <= PH_ENTA;
               end
`ifdef CALC_CHAIN_EN
               else if (is_op) begin
                  if (res_mag > RES_W'(MAX_OPERAND)) begin
                     err   <= 1'b1;
                     state <= PH_ERR;
                  end else begin
                     num1  <= res_mag[NUM_W-1:0];
                     sig1  <= res_neg;
                     oper  <= key_to_oper(key_code);
                     ndig  <= CNT_W'(MAXDIG);
                     state <= PH_ENTOP;
                  end
               end
`endif
            end
            PH_ERR: begin
               // Held until clear or reset
            end
            default: begin
               state <= PH_ENTA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed scenarios plus random key streams vs a digit-list model.
// Latency: outputs sampled on the falling edge after each driven rising edge.
// Backpressure: n/a; a watchdog bounds the run.
module tb_calc_entry_ctrl;

   localparam int TIMEOUT = 1024;
`ifdef CALC_CHAIN_EN
   localparam bit CHAIN = 1'b1;
`else
   localparam bit CHAIN = 1'b0;
`endif

   localparam int P_ENTA = 0, P_ENTOP = 1, P_ENTB = 2, P_EXEC = 3, P_WAIT = 4, P_SHOW = 5, P_ERR = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        key_type = 1'b0;
   logic        op_done = 1'b0;
   logic [19:0] res_mag = 20'd0;
   logic        res_neg = 1'b0;
   logic [9:0]  num1, num2;
   logic        sig1;
   logic [1:0]  oper;
   logic        op_start;
   logic [2:0]  phase;
   logic [1:0]  ndig;
   logic        err;

   int errors = 0;
   int checks = 0;

   // Reference model: operands kept as lists of entered decimal digits
   int qa[$];
   int qb[$];
   bit m_neg;
   int m_op;
   int m_phase;
   int m_res;
   bit m_resneg;

   always #5 clk = ~clk;

   calc_entry_ctrl #(.TIMEOUT(TIMEOUT), .MAXDIG(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_type  (key_type),
      .op_done   (op_done),
      .res_mag   (res_mag),
      .res_neg   (res_neg),
      .num1      (num1),
      .num2      (num2),
      .sig1      (sig1),
      .oper      (oper),
      .op_start  (op_start),
      .phase     (phase),
      .ndig      (ndig),
      .err       (err)
   );

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   function automatic int val_a();
      int v = 0;
      foreach (qa[i]) v = v * 10 + qa[i];
      return v;
   endfunction

   function automatic int val_b();
      int v = 0;
      foreach (qb[i]) v = v * 10 + qb[i];
      return v;
   endfunction

   function automatic void model_clear();
      qa.delete();
      qb.delete();
      m_neg   = 1'b0;
      m_op    = 0;
      m_phase = P_ENTA;
   endfunction

   function automatic void model_key(input bit t, input int c);
      bit dig   = !t && (c <= 9);
      bit arith = t && (c >= 10) && (c <= 13);
      if (t && c == 15) begin
         model_clear();
         return;
      end
      case (m_phase)
         P_ENTA: begin
            if (dig) begin
               if (qa.size() < 3) qa.push_back(c);
            end else if (t && c == 11 && qa.size() == 0) begin
               m_neg = !m_neg;
            end else if (arith && qa.size() > 0) begin
               m_op    = c - 10;
               m_phase = P_ENTOP;
            end
         end
         P_ENTOP: begin
            if (arith) m_op = c - 10;
            else if (dig) begin
               qb.delete();
               qb.push_back(c);
               m_phase = P_ENTB;
            end
         end
         P_ENTB: begin
            if (dig) begin
               if (qb.size() < 3) qb.push_back(c);
            end else if (t && c == 14) begin
               m_phase = (m_op == 3 && val_b() == 0) ? P_ERR : P_EXEC;
            end
         end
         P_SHOW: begin
            if (dig) begin
               qa.delete();
               qb.delete();
               qa.push_back(c);
               m_neg   = 1'b0;
               m_op    = 0;
               m_phase = P_ENTA;
            end else if (arith && CHAIN) begin
               if (m_res > 999) m_phase = P_ERR;
               else begin
                  qa.delete();
                  qa.push_back(m_res / 100);
                  qa.push_back((m_res / 10) % 10);
                  qa.push_back(m_res % 10);
                  m_neg   = m_resneg;
                  m_op    = c - 10;
                  m_phase = P_ENTOP;
               end
            end
         end
         default: begin
         end
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic press(input bit t, input logic [3:0] c);
      key_valid = 1'b1;
      key_type  = t;
      key_code  = c;
      tick();
      key_valid = 1'b0;
      key_type  = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic finish_op(input logic [19:0] mag, input bit neg);
      res_mag = mag;
      res_neg = neg;
      op_done = 1'b1;
      tick();
      op_done = 1'b0;
   endtask

   task automatic run_to_show(input logic [19:0] mag);
      press(0, 4'd1); press(1, 4'hA); press(0, 4'd1); press(1, 4'hE);
      tick();
      finish_op(mag, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({num1, num2, sig1, oper, op_start, phase, ndig, err} !== 30'd0) begin
         errors++;
         $display("FAIL reset_state: got num1=%0d num2=%0d sig1=%b oper=%0d op_start=%b phase=%0d ndig=%0d err=%b, want all zero",
                  num1, num2, sig1, oper, op_start, phase, ndig, err);
      end
      rst = 1'b0;
   endtask

   task automatic test_entry();
      press(0, 4'd1); press(0, 4'd2); press(0, 4'd3);
      checks++;
      if (num1 !== 10'd123 || ndig !== 2'd3) begin
         errors++;
         $display("FAIL entry_three_digits: got num1=%0d ndig=%0d, want 123/3", num1, ndig);
      end
      press(0, 4'd4);
      checks++;
      if (num1 !== 10'd123 || ndig !== 2'd3) begin
         errors++;
         $display("FAIL entry_digit_cap: got num1=%0d ndig=%0d, want 123/3", num1, ndig);
      end
      press(1, 4'hA);
      checks++;
      if (phase !== 3'd1 || oper !== 2'b00) begin
         errors++;
         $display("FAIL entry_operator: got phase=%0d oper=%0d, want 1/0", phase, oper);
      end
      press(0, 4'd5);
      checks++;
      if (phase !== 3'd2 || num2 !== 10'd5 || ndig !== 2'd1) begin
         errors++;
         $display("FAIL entry_operand2: got phase=%0d num2=%0d ndig=%0d, want 2/5/1", phase, num2, ndig);
      end
      press(1, 4'hE);
      checks++;
      if (phase !== 3'd3 || op_start !== 1'b1) begin
         errors++;
         $display("FAIL entry_launch: got phase=%0d op_start=%b, want 3/1", phase, op_start);
      end
      tick();
      checks++;
      if (phase !== 3'd4 || op_start !== 1'b0) begin
         errors++;
         $display("FAIL entry_single_pulse: got phase=%0d op_start=%b, want 4/0", phase, op_start);
      end
      finish_op(20'd128, 1'b0);
      checks++;
      if (phase !== 3'd5) begin
         errors++;
         $display("FAIL entry_show: got phase=%0d, want 5", phase);
      end
      press(1, 4'hF);
   endtask

   task automatic test_sign_mul();
      press(1, 4'hB);
      checks++;
      if (sig1 !== 1'b1 || phase !== 3'd0 || ndig !== 2'd0) begin
         errors++;
         $display("FAIL sign_toggle: got sig1=%b phase=%0d ndig=%0d, want 1/0/0", sig1, phase, ndig);
      end
      press(0, 4'd7); press(1, 4'hC); press(0, 4'd9); press(1, 4'hE);
      tick();
      tick();
      finish_op(20'd63, 1'b1);
      checks++;
      if (phase !== 3'd5 || sig1 !== 1'b1 || oper !== 2'b10 || num1 !== 10'd7 || num2 !== 10'd9) begin
         errors++;
         $display("FAIL sign_mul_show: got phase=%0d sig1=%b oper=%0d num1=%0d num2=%0d, want 5/1/2/7/9",
                  phase, sig1, oper, num1, num2);
      end
   endtask

   task automatic test_chain();
      logic [2:0] exp_ph;
      logic [9:0] exp_n1;
      logic       exp_s;
      logic [1:0] exp_op;
      res_mag = 20'd42;
      res_neg = 1'b0;
      press(1, 4'hA);
      exp_ph = CHAIN ? 3'd1 : 3'd5;
      exp_n1 = CHAIN ? 10'd42 : 10'd7;
      exp_s  = CHAIN ? 1'b0 : 1'b1;
      exp_op = CHAIN ? 2'b00 : 2'b10;
      checks++;
      if (phase !== exp_ph || num1 !== exp_n1 || sig1 !== exp_s || oper !== exp_op) begin
         errors++;
         $display("FAIL chain_small: got phase=%0d num1=%0d sig1=%b oper=%0d, want %0d/%0d/%b/%0d",
                  phase, num1, sig1, oper, exp_ph, exp_n1, exp_s, exp_op);
      end
      press(1, 4'hF);
      run_to_show(20'd1000);
      press(1, 4'hC);
      exp_ph = CHAIN ? 3'd6 : 3'd5;
      checks++;
      if (phase !== exp_ph || err !== CHAIN) begin
         errors++;
         $display("FAIL chain_overflow: got phase=%0d err=%b, want %0d/%b", phase, err, exp_ph, CHAIN);
      end
      press(1, 4'hF);
      checks++;
      if (phase !== 3'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL chain_clear: got phase=%0d err=%b, want 0/0", phase, err);
      end
   endtask

   task automatic test_div_zero();
      bit seen_start = 1'b0;
      press(0, 4'd8); press(1, 4'hD); press(0, 4'd0); press(1, 4'hE);
      seen_start = op_start;
      checks++;
      if (phase !== 3'd6 || err !== 1'b1) begin
         errors++;
         $display("FAIL div_zero_err: got phase=%0d err=%b, want 6/1", phase, err);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (op_start !== 1'b0) seen_start = 1'b1;
      end
      checks++;
      if (seen_start !== 1'b0) begin
         errors++;
         $display("FAIL div_zero_no_start: got op_start pulse=%b, want 0", seen_start);
      end
      press(0, 4'd5);
      checks++;
      if (phase !== 3'd6 || num2 !== 10'd0) begin
         errors++;
         $display("FAIL err_ignores_keys: got phase=%0d num2=%0d, want 6/0", phase, num2);
      end
      press(1, 4'hF);
      checks++;
      if ({num1, num2, sig1, oper, op_start, phase, ndig, err} !== 30'd0) begin
         errors++;
         $display("FAIL clear_from_err: got num1=%0d num2=%0d sig1=%b oper=%0d phase=%0d ndig=%0d err=%b, want all zero",
                  num1, num2, sig1, oper, phase, ndig, err);
      end
   endtask

   task automatic test_timeout();
      bit early = 1'b0;
      press(0, 4'd2); press(1, 4'hA); press(0, 4'd3); press(1, 4'hE);
      checks++;
      if (op_start !== 1'b1) begin
         errors++;
         $display("FAIL timeout_launch: got op_start=%b, want 1", op_start);
      end
      for (int i = 1; i < TIMEOUT; i++) begin
         if (i == 10) press(0, 4'd7);
         else tick();
         if (err !== 1'b0) early = 1'b1;
      end
      checks++;
      if (early !== 1'b0 || phase !== 3'd4) begin
         errors++;
         $display("FAIL timeout_early: got early_err=%b phase=%0d, want 0/4", early, phase);
      end
      tick();
      checks++;
      if (err !== 1'b1 || phase !== 3'd6) begin
         errors++;
         $display("FAIL timeout_expire: got err=%b phase=%0d, want 1/6", err, phase);
      end
      checks++;
      if (num1 !== 10'd2) begin
         errors++;
         $display("FAIL wait_ignores_keys: got num1=%0d, want 2", num1);
      end
      press(1, 4'hF);
   endtask

   task automatic test_rst_wait();
      press(0, 4'd4); press(1, 4'hC); press(0, 4'd6); press(1, 4'hE);
      tick();
      checks++;
      if (phase !== 3'd4) begin
         errors++;
         $display("FAIL rst_wait_setup: got phase=%0d, want 4", phase);
      end
      rst     = 1'b1;
      op_done = 1'b1;
      res_mag = 20'd24;
      tick();
      rst = 1'b0;
      checks++;
      if ({num1, num2, sig1, oper, op_start, phase, ndig, err} !== 30'd0) begin
         errors++;
         $display("FAIL rst_in_wait: got num1=%0d num2=%0d sig1=%b oper=%0d phase=%0d ndig=%0d err=%b, want all zero",
                  num1, num2, sig1, oper, phase, ndig, err);
      end
      tick();
      op_done = 1'b0;
      checks++;
      if ({num1, num2, sig1, oper, op_start, phase, ndig, err} !== 30'd0) begin
         errors++;
         $display("FAIL late_op_done: got phase=%0d num1=%0d op_start=%b err=%b, want all zero",
                  phase, num1, op_start, err);
      end
   endtask

   task automatic test_random();
      int  r, c;
      bit  t;
      logic [1:0] exp_nd;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      m_res    = 0;
      m_resneg = 1'b0;
      res_mag  = 20'd0;
      res_neg  = 1'b0;
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         if (r < 55)      begin t = 1'b0; c = $urandom_range(0, 9);   end
         else if (r < 60) begin t = 1'b0; c = $urandom_range(10, 15); end
         else if (r < 92) begin t = 1'b1; c = $urandom_range(10, 14); end
         else if (r < 95) begin t = 1'b1; c = $urandom_range(0, 9);   end
         else             begin t = 1'b1; c = 15;                     end
         press(t, 4'(c));
         model_key(t, c);
         checks++;
         if (num1 !== 10'(val_a()) || num2 !== 10'(val_b()) || sig1 !== m_neg || oper !== 2'(m_op) ||
             phase !== 3'(m_phase) || err !== (m_phase == P_ERR)) begin
            errors++;
            $display("FAIL rand_state key %0d (t=%0d c=%0d): got num1=%0d num2=%0d sig1=%b oper=%0d phase=%0d err=%b, want num1=%0d num2=%0d sig1=%b oper=%0d phase=%0d",
                     n, t, c, num1, num2, sig1, oper, phase, err, val_a(), val_b(), m_neg, m_op, m_phase);
         end
         if (m_phase <= P_ENTB) begin
            exp_nd = (m_phase == P_ENTB) ? 2'(qb.size()) : 2'(qa.size());
            checks++;
            if (ndig !== exp_nd) begin
               errors++;
               $display("FAIL rand_ndig key %0d: got ndig=%0d, want %0d", n, ndig, exp_nd);
            end
         end
         if (m_phase == P_EXEC) begin
            checks++;
            if (op_start !== 1'b1) begin
               errors++;
               $display("FAIL rand_launch key %0d: got op_start=%b, want 1", n, op_start);
            end
            tick();
            checks++;
            if (op_start !== 1'b0 || phase !== 3'd4) begin
               errors++;
               $display("FAIL rand_wait key %0d: got op_start=%b phase=%0d, want 0/4", n, op_start, phase);
            end
            repeat ($urandom_range(0, 4)) tick();
            m_res    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1000, 20'hFFFFF)) : int'($urandom_range(0, 999));
            m_resneg = 1'($urandom_range(0, 1));
            finish_op(20'(m_res), m_resneg);
            m_phase = P_SHOW;
            checks++;
            if (phase !== 3'd5) begin
               errors++;
               $display("FAIL rand_show key %0d: got phase=%0d, want 5", n, phase);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_entry();
      test_sign_mul();
      test_chain();
      test_div_zero();
      test_timeout();
      test_rst_wait();
      test_random();
      if (errors == 0)
         $display("PASS Result: errors=%0d of %0d checks", errors, checks);
      else
         $display("FAIL Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
